// File: rtl/nw_pkg.sv
// Shared constants for the Needleman-Wunsch fill datapath: score format,
// saturation bounds, direction codes, FSM encodings and default scoring.
package nw_pkg;

  localparam int SCORE_W = 9;
  localparam int CALC_W  = 11;

  localparam logic signed [CALC_W-1:0] SAT_MIN_C = -11'sd256;
  localparam logic signed [CALC_W-1:0] SAT_MAX_C = 11'sd255;

  localparam logic [1:0] DIR_DIAG = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_LEFT = 2'b10;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_LATCH = 3'd2;
  localparam logic [2:0] ST_COMP  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_NEXT  = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  localparam int DEF_MATCH    = 1;
  localparam int DEF_MISMATCH = -1;
  localparam int DEF_GAP      = -2;

  function automatic logic signed [CALC_W-1:0] extScore(input logic [SCORE_W-1:0] s);
    return $signed({{(CALC_W-SCORE_W){s[SCORE_W-1]}}, s});
  endfunction

  // Clamp the widened sum back into the 9-bit two's complement range.
  function automatic logic [SCORE_W-1:0] satScore(input logic signed [CALC_W-1:0] v);
    if (v < SAT_MIN_C) begin
      return 9'h100;
    end else if (v > SAT_MAX_C) begin
      return 9'h0FF;
    end else begin
      return v[SCORE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/nw_cell_max.sv
// Combinational cell evaluation: three candidate sums, saturation and a
// priority maximum (diag beats up beats left on ties).
module nw_cell_max
  import nw_pkg::*;
#(
  parameter int MATCH    = DEF_MATCH,
  parameter int MISMATCH = DEF_MISMATCH,
  parameter int GAP      = DEF_GAP
) (
  input  logic [SCORE_W-1:0] diag_i,
  input  logic [SCORE_W-1:0] left_i,
  input  logic [SCORE_W-1:0] up_i,
  input  logic [1:0]         a_char_i,
  input  logic [1:0]         b_char_i,
  output logic [SCORE_W-1:0] max_o,
  output logic [1:0]         dir_o
);

  localparam logic signed [CALC_W-1:0] MATCH_C    = CALC_W'(MATCH);
  localparam logic signed [CALC_W-1:0] MISMATCH_C = CALC_W'(MISMATCH);
  localparam logic signed [CALC_W-1:0] GAP_C      = CALC_W'(GAP);

  logic signed [CALC_W-1:0] dSum, uSum, lSum;
  logic [SCORE_W-1:0]       dSat, uSat, lSat;

  assign dSum = extScore(diag_i) + ((a_char_i == b_char_i) ? MATCH_C : MISMATCH_C);
  assign uSum = extScore(up_i) + GAP_C;
  assign lSum = extScore(left_i) + GAP_C;

  assign dSat = satScore(dSum);
  assign uSat = satScore(uSum);
  assign lSat = satScore(lSum);

  // Compare after clamping so candidates that saturate together tie cleanly.
  always_comb begin
    max_o = lSat;
    dir_o = DIR_LEFT;
    if (($signed(dSat) >= $signed(uSat)) && ($signed(dSat) >= $signed(lSat))) begin
      max_o = dSat;
      dir_o = DIR_DIAG;
    end else if ($signed(uSat) >= $signed(lSat)) begin
      max_o = uSat;
      dir_o = DIR_UP;
    end
  end

endmodule

// File: rtl/nw_cell_engine.sv
// Row-major fill controller for the Needleman-Wunsch score matrix: fetches
// three neighbours, evaluates one cell and writes its score and direction.
module nw_cell_engine
  import nw_pkg::*;
#(
  parameter int N        = 128,
  parameter int MATCH    = DEF_MATCH,
  parameter int MISMATCH = DEF_MISMATCH,
  parameter int GAP      = DEF_GAP,
  localparam int BitAddr = $clog2(N + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         a_char,
  input  logic [1:0]         b_char,
  input  logic               signal,
  input  logic [SCORE_W-1:0] diag,
  input  logic [SCORE_W-1:0] left,
  input  logic [SCORE_W-1:0] up,
  output logic [BitAddr:0]   i,
  output logic [BitAddr:0]   j,
  output logic               en_read,
  output logic               en_counter_3,
  output logic               en_ins,
  output logic               we,
  output logic [SCORE_W-1:0] max,
  output logic [1:0]         dir,
  output logic               dir_we,
  output logic               busy,
  output logic               done
);

  localparam logic [BitAddr:0] IDX_ONE  = (BitAddr + 1)'(1);
  localparam logic [BitAddr:0] IDX_LAST = (BitAddr + 1)'(N);

  logic [2:0]         state_q, state_d;
  logic [BitAddr:0]   i_q, i_d, j_q, j_d;
  logic [SCORE_W-1:0] diag_q, diag_d, left_q, left_d, up_q, up_d;
  logic [SCORE_W-1:0] max_q, max_d;
  logic [1:0]         dir_q, dir_d;
  logic [SCORE_W-1:0] cellMax;
  logic [1:0]         cellDir;

  nw_cell_max #(
    .MATCH    (MATCH),
    .MISMATCH (MISMATCH),
    .GAP      (GAP)
  ) u_cell_max (
    .diag_i   (diag_q),
    .left_i   (left_q),
    .up_i     (up_q),
    .a_char_i (a_char),
    .b_char_i (b_char),
    .max_o    (cellMax),
    .dir_o    (cellDir)
  );

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    diag_d  = diag_q;
    left_d  = left_q;
    up_d    = up_q;
    max_d   = max_q;
    dir_d   = dir_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          i_d     = IDX_ONE;
          j_d     = IDX_ONE;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (signal) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        diag_d  = diag;
        left_d  = left;
        up_d    = up;
        state_d = ST_COMP;
      end
      ST_COMP: begin
        max_d   = cellMax;
        dir_d   = cellDir;
        state_d = ST_WRITE;
      end
      ST_WRITE: state_d = ST_NEXT;
      // Coordinates move here so the sequence RAMs have the whole READ
      // phase to present the new characters before COMP samples them.
      ST_NEXT: begin
        if (j_q < IDX_LAST) begin
          j_d     = j_q + IDX_ONE;
          state_d = ST_READ;
        end else if (i_q < IDX_LAST) begin
          j_d     = IDX_ONE;
          i_d     = i_q + IDX_ONE;
          state_d = ST_READ;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      diag_q  <= '0;
      left_q  <= '0;
      up_q    <= '0;
      max_q   <= '0;
      dir_q   <= DIR_DIAG;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      diag_q  <= diag_d;
      left_q  <= left_d;
      up_q    <= up_d;
      max_q   <= max_d;
      dir_q   <= dir_d;
    end
  end

  // Strobes decode straight from the state register, so an asynchronous
  // reset kills them in the same cycle without any partial pulse.
  assign en_read      = (state_q == ST_READ);
  assign en_counter_3 = (state_q == ST_READ);
  assign en_ins       = (state_q == ST_WRITE);
  assign we           = (state_q == ST_WRITE);
  assign dir_we       = (state_q == ST_WRITE);
  assign done         = (state_q == ST_DONE);
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign i            = i_q;
  assign j            = j_q;
  assign max          = max_q;
  assign dir          = dir_q;

endmodule

// File: tb/tb_nw_cell_engine.sv
// Directed bench for nw_cell_engine with a small score-manager/sequence-RAM
// responder and a reference Needleman-Wunsch matrix for N=4.
module tb_nw_cell_engine;

  localparam int N  = 4;
  localparam int BW = $clog2(N + 1);

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  a_char, b_char;
  logic        signal;
  logic [8:0]  diag, left, up;
  logic [BW:0] i, j;
  logic        en_read, en_counter_3, en_ins, we, dir_we, busy, done;
  logic [8:0]  max;
  logic [1:0]  dir;

  int vectors = 0;
  int errors  = 0;

  int         refH   [0:N][0:N];
  logic [1:0] refDir [0:N][0:N];
  logic [1:0] seqA   [0:N-1];
  logic [1:0] seqB   [0:N-1];

  int         sigDelay = 3;
  int         readCnt  = 0;
  bit         override = 0;
  logic [8:0] ovDiag, ovUp, ovLeft;
  logic [1:0] ovA, ovB;

  nw_cell_engine #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .a_char       (a_char),
    .b_char       (b_char),
    .signal       (signal),
    .diag         (diag),
    .left         (left),
    .up           (up),
    .i            (i),
    .j            (j),
    .en_read      (en_read),
    .en_counter_3 (en_counter_3),
    .en_ins       (en_ins),
    .we           (we),
    .max          (max),
    .dir          (dir),
    .dir_we       (dir_we),
    .busy         (busy),
    .done         (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Score manager and sequence RAM stand-in, updated on the falling edge.
  initial begin : responder
    signal = 1'b0;
    diag   = '0;
    left   = '0;
    up     = '0;
    a_char = '0;
    b_char = '0;
    forever begin
      @(negedge clk);
      if (en_read) begin
        readCnt++;
        signal = (readCnt == sigDelay);
      end else begin
        readCnt = 0;
        signal  = 1'b0;
      end
      if (override) begin
        diag   = ovDiag;
        up     = ovUp;
        left   = ovLeft;
        a_char = ovA;
        b_char = ovB;
      end else if (i >= 1 && i <= N && j >= 1 && j <= N) begin
        diag   = 9'(refH[int'(i) - 1][int'(j) - 1]);
        up     = 9'(refH[int'(i) - 1][int'(j)]);
        left   = 9'(refH[int'(i)][int'(j) - 1]);
        a_char = seqA[int'(i) - 1];
        b_char = seqB[int'(j) - 1];
      end
    end
  end

  task automatic buildReference;
    int d, u, l;
    seqA[0] = 2'd0; seqA[1] = 2'd1; seqA[2] = 2'd2; seqA[3] = 2'd3;
    seqB[0] = 2'd0; seqB[1] = 2'd1; seqB[2] = 2'd2; seqB[3] = 2'd3;
    for (int k = 0; k <= N; k++) begin
      refH[0][k] = -2 * k;
      refH[k][0] = -2 * k;
    end
    for (int r = 1; r <= N; r++) begin
      for (int c = 1; c <= N; c++) begin
        d = refH[r-1][c-1] + ((seqA[r-1] == seqB[c-1]) ? 1 : -1);
        u = refH[r-1][c] - 2;
        l = refH[r][c-1] - 2;
        if (d >= u && d >= l) begin
          refH[r][c] = d; refDir[r][c] = 2'b00;
        end else if (u >= l) begin
          refH[r][c] = u; refDir[r][c] = 2'b01;
        end else begin
          refH[r][c] = l; refDir[r][c] = 2'b10;
        end
      end
    end
  endtask

  task automatic pulseStart;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic applyReset;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic waitWrite(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (en_ins) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic runCell(input logic [8:0] d, input logic [8:0] u, input logic [8:0] l,
                         input logic [1:0] a, input logic [1:0] b, output bit seen);
    ovDiag   = d;
    ovUp     = u;
    ovLeft   = l;
    ovA      = a;
    ovB      = b;
    override = 1'b1;
    pulseStart();
    waitWrite(seen);
  endtask

  task automatic test_reset;
    rst   = 1'b0;
    start = 1'b0;
    #12;
    vectors++;
    if ({busy, done, en_read, en_counter_3, en_ins, we, dir_we} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_strobes: got %b expected 0000000",
               {busy, done, en_read, en_counter_3, en_ins, we, dir_we});
    end
    vectors++;
    if (i !== '0 || j !== '0) begin
      errors++;
      $display("[TB] FAIL reset_ij: got i=%0d j=%0d expected 0 0", i, j);
    end
    vectors++;
    if (max !== 9'h000 || dir !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_maxdir: got max=%h dir=%b expected 000 00", max, dir);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fill;
    int ii = 1, jj = 1, writes = 0, dones = 0, sinceDone = -1;
    logic [8:0] lastMax = '0;
    override = 1'b0;
    sigDelay = 3;
    pulseStart();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (en_ins) begin
        vectors++;
        if (!(we && dir_we && busy)) begin
          errors++;
          $display("[TB] FAIL fill_strobes: got we=%b dir_we=%b busy=%b expected 1 1 1", we, dir_we, busy);
        end
        vectors++;
        if (i !== BW'(ii) || j !== BW'(jj)) begin
          errors++;
          $display("[TB] FAIL fill_order: got (%0d,%0d) expected (%0d,%0d)", i, j, ii, jj);
        end
        if (ii <= N && jj <= N) begin
          vectors++;
          if (max !== 9'(refH[ii][jj]) || dir !== refDir[ii][jj]) begin
            errors++;
            $display("[TB] FAIL fill_cell (%0d,%0d): got max=%h dir=%b expected max=%h dir=%b",
                     ii, jj, max, dir, 9'(refH[ii][jj]), refDir[ii][jj]);
          end
        end
        lastMax = max;
        writes++;
        if (jj < N) jj++;
        else begin jj = 1; ii++; end
      end
      if (done) begin
        dones++;
        if (sinceDone < 0) sinceDone = 0;
      end
      if (sinceDone >= 0) begin
        sinceDone++;
        if (sinceDone > 6) break;
      end
    end
    vectors++;
    if (writes !== 16) begin
      errors++;
      $display("[TB] FAIL fill_count: got %0d writes expected 16", writes);
    end
    vectors++;
    if (dones !== 1) begin
      errors++;
      $display("[TB] FAIL fill_done: got %0d done pulses expected 1", dones);
    end
    vectors++;
    if (lastMax !== 9'd4) begin
      errors++;
      $display("[TB] FAIL fill_final: got max=%h expected 004", lastMax);
    end
    vectors++;
    if (busy !== 1'b0 || i !== BW'(4) || j !== BW'(4)) begin
      errors++;
      $display("[TB] FAIL fill_idle: got busy=%b i=%0d j=%0d expected 0 4 4", busy, i, j);
    end
  endtask

  task automatic test_tie;
    bit seen;
    runCell(9'h000, 9'h001, 9'h001, 2'd0, 2'd1, seen);
    vectors++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL tie_timeout: got no en_ins expected one");
    end else if (max !== 9'h1FF || dir !== 2'b00) begin
      errors++;
      $display("[TB] FAIL tie: got max=%h dir=%b expected 1ff 00", max, dir);
    end
    applyReset();
  endtask

  task automatic test_up_win;
    bit seen;
    runCell(9'h1F6, 9'h005, 9'h000, 2'd1, 2'd2, seen);
    vectors++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL up_timeout: got no en_ins expected one");
    end else if (max !== 9'h003 || dir !== 2'b01) begin
      errors++;
      $display("[TB] FAIL up_win: got max=%h dir=%b expected 003 01", max, dir);
    end
    applyReset();
  endtask

  task automatic test_left_win;
    bit seen;
    runCell(9'h1F6, 9'h000, 9'h005, 2'd3, 2'd0, seen);
    vectors++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL left_timeout: got no en_ins expected one");
    end else if (max !== 9'h003 || dir !== 2'b10) begin
      errors++;
      $display("[TB] FAIL left_win: got max=%h dir=%b expected 003 10", max, dir);
    end
    applyReset();
  endtask

  task automatic test_saturation;
    bit seen;
    runCell(9'h100, 9'h100, 9'h100, 2'd0, 2'd3, seen);
    vectors++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL sat_timeout: got no en_ins expected one");
    end else if (max !== 9'h100 || dir !== 2'b00) begin
      errors++;
      $display("[TB] FAIL saturation: got max=%h dir=%b expected 100 00", max, dir);
    end
    applyReset();
  endtask

  task automatic test_handshake;
    int readCycles = 0, gap = 0;
    sigDelay = 6;
    runCellSetup();
    pulseStart();
    for (int c = 0; c < 20; c++) begin
      if (en_read) break;
      @(negedge clk);
    end
    for (int c = 0; c < 50; c++) begin
      if (!en_read) break;
      readCycles++;
      @(negedge clk);
    end
    gap = 1;
    while (!en_ins && gap < 10) begin
      @(negedge clk);
      gap++;
    end
    vectors++;
    if (readCycles !== 6) begin
      errors++;
      $display("[TB] FAIL hs_read_len: got %0d cycles expected 6", readCycles);
    end
    vectors++;
    if (gap !== 3 || !en_ins) begin
      errors++;
      $display("[TB] FAIL hs_ins_delay: got %0d cycles expected 3", gap);
    end
    applyReset();
    sigDelay = 3;
  endtask

  task automatic runCellSetup;
    ovDiag   = 9'h000;
    ovUp     = 9'h000;
    ovLeft   = 9'h000;
    ovA      = 2'd0;
    ovB      = 2'd0;
    override = 1'b1;
  endtask

  task automatic test_reset_mid_fill;
    bit hit = 1'b0, seen;
    override = 1'b0;
    sigDelay = 3;
    pulseStart();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (en_ins && i == BW'(2) && j == BW'(3)) begin
        hit = 1'b1;
        break;
      end
    end
    vectors++;
    if (!hit) begin
      errors++;
      $display("[TB] FAIL rst_reach: got no write of (2,3) expected one");
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({en_ins, we, dir_we, busy} !== 4'b0) begin
      errors++;
      $display("[TB] FAIL rst_strobes: got %b expected 0000", {en_ins, we, dir_we, busy});
    end
    vectors++;
    if (i !== '0 || j !== '0) begin
      errors++;
      $display("[TB] FAIL rst_ij: got i=%0d j=%0d expected 0 0", i, j);
    end
    @(negedge clk);
    rst = 1'b1;
    pulseStart();
    waitWrite(seen);
    vectors++;
    if (!seen || i !== BW'(1) || j !== BW'(1) || max !== 9'h001) begin
      errors++;
      $display("[TB] FAIL rst_restart: got seen=%b (%0d,%0d) max=%h expected 1 (1,1) 001",
               seen, i, j, max);
    end
    applyReset();
  endtask

  initial begin : main
    start = 1'b0;
    rst   = 1'b0;
    buildReference();
    test_reset();
    test_fill();
    test_tie();
    test_up_win();
    test_left_win();
    test_saturation();
    test_handshake();
    test_reset_mid_fill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/nw_cell_engine.md
# nw_cell_engine

Control-and-compute stage that fills the Needleman-Wunsch score matrix, one cell per iteration, in row-major order. It sits beside the score manager: it drives the manager's read handshake to fetch the diagonal, left and up neighbours of cell (i,j). It then computes the cell score and a traceback direction, and returns the score through the manager's insert port. It also emits the direction word for the downstream traceback RAM.

## Interface
- N, 128, sequence length; the matrix is (N+1)x(N+1), and row/column 0 are preloaded by the init path.
- BitAddr, $clog2(N+1), index width; i/j ports are BitAddr+1 bits.
- MATCH, 1, signed score added on a character match.
- MISMATCH, -1, signed score added on a mismatch.
- GAP, -2, signed score added for the up/left moves.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle pulse; starts a fill when idle
- a_char  in  2  base of sequence A at row i; valid one cycle after i changes
- b_char  in  2  base of sequence B at column j; valid one cycle after j changes
- signal  in  1  score manager's 3-read-complete pulse
- diag, left, up  in  9  neighbour scores from the score manager, two's complement
- i, j  out  BitAddr+1  current cell coordinates; also address the sequence RAMs
- en_read  out  1  enables the score manager read path
- en_counter_3  out  1  enables the manager's read counter
- en_ins  out  1  insert-enable to the score manager
- we  out  1  write strobe to the score RAM
- max  out  9  computed cell score, two's complement
- dir  out  2  direction: 00 diag, 01 up, 10 left
- dir_we  out  1  direction-RAM write strobe, coincident with we
- busy  out  1  high from start accepted until done
- done  out  1  one-cycle pulse after the last cell is written

## Operation
- FSM states: IDLE, READ, LATCH, COMP, WRITE, NEXT, DONE.
- IDLE: on start, load i=1, j=1, raise busy, go to READ. start is ignored while busy.
- READ: hold en_read=en_counter_3=1 until signal is sampled high, then go to LATCH.
- LATCH: register diag/left/up; en_read and en_counter_3 drop.
- COMP: the three candidate scores are:
  - d = diag + (a_char==b_char ? MATCH : MISMATCH)
  - u = up + GAP
  - l = left + GAP
  - Evaluate in 11-bit signed, then saturate to [-256, +255].
  - Register max and dir. Tie priority is diag > up > left.
- WRITE: assert en_ins=we=dir_we=1 for exactly one cycle; max/dir are stable on that cycle.
- NEXT: advance the coordinates and choose the next state:
  - If j<N: j++ and go to READ.
  - Else if i<N: j=1, i++ and go to READ.
  - Else go to DONE.
- DONE: pulse done for one cycle, clear busy, go to IDLE; i/j hold their last values.
- en_init is never driven by this block. The init phase must finish before start.

## Timing
- Reset values: state IDLE; i=j=0; max=0; dir=00; all strobes, busy and done are 0.
- Per cell: READ lasts R cycles (R = cycles until signal, nominally 3), followed by LATCH, COMP, WRITE and NEXT. Total R+4 cycles.
- Characters: i/j change in NEXT, and a_char/b_char are sampled in COMP, at least R+1 cycles later. The one-cycle sequence-RAM latency is therefore met.
- A write in WRITE of cell k is visible to the READ of cell k+1, as the RAM is write-first over a ≥1-cycle gap.
- If signal arrives in the same cycle as READ entry, it is honoured.
- A signal pulse outside READ is ignored.
- Asynchronous rst mid-fill returns immediately to reset values. No partial write strobe may be emitted.
- Saturation: the sum is clamped to -256 for any value below -256 and to 255 for any value above 255.

## Structure
- Shared package nw_pkg holds:
  - score width (9) and the saturation bounds
  - dir encodings DIR_DIAG/DIR_UP/DIR_LEFT
  - FSM state encodings
  - default MATCH/MISMATCH/GAP
- One sub-module, nw_cell_max: a combinational 3-way add, saturate and priority-max, returning {max, dir}. The parent registers its outputs in COMP.

## Test plan
- Reset, then pulse start with N=4 and A=B=ACGT, neighbours modelled by a reference matrix. Required: 16 WRITE strobes in row-major order (1,1)…(4,4); final max=4 at (4,4); all dir=00 on the diagonal; done pulses once.
- Single-cell tie, diag=0, up=1, left=1, mismatch: d=-1, u=-1, l=-1. Required: max=-1 (0x1FF), dir=00.
- Up-only win, diag=-10, up=5, left=0, mismatch. Required: max=3, dir=01.
- Saturation with diag=up=left=-256 and a mismatch. Required: max=-256 (0x100), not a wrapped positive value.
- Handshake: delay signal by 6 cycles in READ. Required: en_read stays high 6 cycles, and en_ins follows exactly 3 cycles after the cycle signal is sampled.
- Drive rst low during the WRITE of cell (2,3). Required: en_ins/we/dir_we low in the same cycle, busy=0, i=j=0; a later start restarts from (1,1).
